irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller for the single-cycle MIPS core. It drives the `IRQ` input of the control unit, which redirects PC to the exception vector (PCSrc=4), writes PC+4 to $k0 (RegDst=3, MemToReg=3) and suppresses memory writes.
- Edge-detects external sources, holds pending/enable state and prioritises pending sources.
- Issues exactly one single-cycle IRQ per service, then waits for the handler to leave kernel mode.
- Software sees it as memory-mapped registers on the peripheral bus.

Parameters:
- N_SRC, 8, number of interrupt sources (1..16); index 0 is highest priority.
- BASE_ADDR, 32'h4000_0020, byte address of the first register.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- src  input  N_SRC  raw interrupt sources, synchronous to clk; a rising edge requests service.
- pc_kernel  input  1  PC[31] of the instruction executing this cycle (1 = kernel mode).
- addr  input  32  bus byte address.
- wdata  input  32  bus write data.
- wr  input  1  bus write strobe (MemWr).
- rd  input  1  bus read strobe (MemRd).
- rdata  output  32  read data; combinational from addr; 0 when not rd or unmapped.
- irq  output  1  to the control unit `IRQ` input; registered.
- cause  output  5  {valid, index[3:0]} of the source being serviced; registered.

Behaviour:
- Reset (synchronous, dominates all other events): IE=0, IP=0, GIE=0, src_q=0, state=IDLE, irq=0, cause=0, pc_kernel_q=0.
- Edge detect: src_q <= src. Set vector = src & ~src_q. IP[i] <= 1 on set[i].
- Register map (word offsets from BASE_ADDR):
  - +0x0 IE: R/W mask, N_SRC bits, upper bits read 0.
  - +0x4 IP: read pending; write-1-to-clear. A set edge and a W1C on the same bit in the same cycle leave IP=1 (set wins).
  - +0x8 CAUSE: read {27'b0, cause}; writes ignored.
  - +0xC GIE: bit0 R/W global enable.
  - Unmapped offsets: writes ignored, reads 0.
  - A write takes effect at the next edge. Reads in the same cycle return old values.
- req = |(IP & IE) & GIE & ~pc_kernel, evaluated combinationally on current register values.
- The priority encoder picks the lowest set index of IP & IE.
- FSM:
  - IDLE: if req, go to REQ next edge, set irq<=1 and cause<={1,idx}. Otherwise stay.
  - REQ: irq is 1 for exactly this one cycle; the CPU takes the exception on it. Next edge goes to SERVICE with irq<=0.
  - SERVICE: irq=0. Exit to IDLE on the falling edge of pc_kernel (pc_kernel_q=1, pc_kernel=0), i.e. the handler's jr $k0 to user space. cause holds until the exit edge, then its valid bit clears. No new irq while in SERVICE, even if other sources are pending.
- Latency: from a src rising edge to irq=1 is 2 cycles (edge detect, IP set, then the FSM registers irq).
- Pending handling:
  - IP is never cleared by hardware; software clears the serviced bit via W1C before returning.
  - If the bit is not cleared, the FSM re-requests one cycle after returning to IDLE.
- Masking: clearing IE or GIE while in REQ does not retract the in-flight irq. While in IDLE it prevents the request.
- Kernel mode: while pc_kernel=1 in IDLE (syscall or boot code), requests are held pending and never dropped.

Decomposition:
- Package irq_pkg: register offsets (OFF_IE=0, OFF_IP=4, OFF_CAUSE=8, OFF_GIE=12), FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), and the cause width.
- Sub-module irq_prio_enc: parameterised lowest-index-first priority encoder; outputs {valid, index}.

Test Plan:
- Reset, then program IE=0x01 and GIE=1, pulse src[0] at cycle 10 with pc_kernel=0 → irq=1 only at cycle 12, cause=5'b1_0000, IP=0x01.
- In SERVICE, drive src[1] high with IE=0x03 → no irq. Then pc_kernel 1→0 with IP[0] cleared by W1C → irq=1 two cycles after the exit edge, cause=5'b1_0001.
- Sources 2 and 5 rise in the same cycle with IE=0xFF → cause index 2 first. After W1C 0x04 and return, the second irq has cause index 5.
- Write IP=0x01 (W1C) in the same cycle src[0] rises → IP[0] stays 1.
- Hold pc_kernel=1 with IP&IE≠0 and GIE=1 → irq stays 0. Drop pc_kernel to 0 → irq asserts next edge.
- Assert reset during REQ → next cycle irq=0, cause=0, IE=IP=GIE=0, and reading rdata at BASE_ADDR+4 returns 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM states, cause width.
package irq_pkg;

  localparam logic [3:0] OFF_IE    = 4'h0;
  localparam logic [3:0] OFF_IP    = 4'h4;
  localparam logic [3:0] OFF_CAUSE = 4'h8;
  localparam logic [3:0] OFF_GIE   = 4'hC;

  localparam int CAUSE_W = 5;
  localparam int IDX_W   = CAUSE_W - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder returning {valid, index}.
module irq_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = |req;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detected sources, IE/IP/GIE registers on the peripheral
// bus, and a one-shot IRQ handshake that waits for the handler to return to user mode.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0020
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   src,
  input  logic               pc_kernel,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               wr,
  input  logic               rd,
  output logic [31:0]        rdata,
  output logic               irq,
  output logic [CAUSE_W-1:0] cause
);

  logic [N_SRC-1:0]   ie_reg, ip_reg, src_q_reg;
  logic [N_SRC-1:0]   ie_next, ip_next, set_vec, w1c_vec;
  logic               gie_reg, gie_next, pc_kernel_q_reg;
  state_t             state_reg, state_next;
  logic               irq_reg, irq_next;
  logic [CAUSE_W-1:0] cause_reg, cause_next;

  logic [31:0]        offset;
  logic               mapped;
  logic [3:0]         reg_sel;
  logic               pend_valid;
  logic [IDX_W-1:0]   pend_idx;
  logic               req;
  logic               unused_wdata;

  // Only word-aligned offsets inside the 16-byte window decode to a register.
  assign offset  = addr - BASE_ADDR;
  assign mapped  = (offset[31:4] == 28'd0) && (offset[1:0] == 2'b00);
  assign reg_sel = offset[3:0];

  assign set_vec  = src & ~src_q_reg;
  assign w1c_vec  = (wr && mapped && reg_sel == OFF_IP) ? wdata[N_SRC-1:0] : '0;
  assign ie_next  = (wr && mapped && reg_sel == OFF_IE) ? wdata[N_SRC-1:0] : ie_reg;
  assign gie_next = (wr && mapped && reg_sel == OFF_GIE) ? wdata[0] : gie_reg;
  assign unused_wdata = ^wdata;

  // A new edge on a bit overrides a simultaneous software clear.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ip
      assign ip_next[gi] = set_vec[gi] | (ip_reg[gi] & ~w1c_vec[gi]);
    end
  endgenerate

  irq_prio_enc #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio (
    .req   (ip_reg & ie_reg),
    .valid (pend_valid),
    .index (pend_idx)
  );

  assign req = pend_valid & gie_reg & ~pc_kernel;

  always_comb begin
    state_next = state_reg;
    irq_next   = 1'b0;
    cause_next = cause_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = REQ;
          irq_next   = 1'b1;
          cause_next = {1'b1, pend_idx};
        end
      end
      REQ: state_next = SERVICE;
      SERVICE: begin
        // Handler's return to user space shows up as a falling edge of PC[31].
        if (pc_kernel_q_reg && !pc_kernel) begin
          state_next = IDLE;
          cause_next = {1'b0, cause_reg[IDX_W-1:0]};
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_reg          <= '0;
      ip_reg          <= '0;
      gie_reg         <= 1'b0;
      src_q_reg       <= '0;
      pc_kernel_q_reg <= 1'b0;
      state_reg       <= IDLE;
      irq_reg         <= 1'b0;
      cause_reg       <= '0;
    end else begin
      ie_reg          <= ie_next;
      ip_reg          <= ip_next;
      gie_reg         <= gie_next;
      src_q_reg       <= src;
      pc_kernel_q_reg <= pc_kernel;
      state_reg       <= state_next;
      irq_reg         <= irq_next;
      cause_reg       <= cause_next;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && mapped) begin
      case (reg_sel)
        OFF_IE:    rdata[N_SRC-1:0]   = ie_reg;
        OFF_IP:    rdata[N_SRC-1:0]   = ip_reg;
        OFF_CAUSE: rdata[CAUSE_W-1:0] = cause_reg;
        OFF_GIE:   rdata[0]           = gie_reg;
        default:   rdata = '0;
      endcase
    end
  end

  assign irq   = irq_reg;
  assign cause = cause_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the controller.
module tb_irq_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  src = '0;
  logic        pc_kernel = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] rdata;
  logic        irq;
  logic [4:0]  cause;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Behavioural model state
  bit [7:0] m_ie, m_ip, m_src_prev;
  bit       m_gie, m_pk_prev, m_irq;
  bit [4:0] m_cause;
  int       m_phase;  // 0: waiting, 1: irq cycle, 2: handler running

  irq_ctrl #(.N_SRC(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .src(src), .pc_kernel(pc_kernel),
    .addr(addr), .wdata(wdata), .wr(wr), .rd(rd),
    .rdata(rdata), .irq(irq), .cause(cause)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  function automatic int lowest(bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit [31:0] model_read(bit r, bit [31:0] a);
    bit [31:0] off;
    off = a - BASE;
    if (!r || off > 32'd15 || off[1:0] != 2'b00) return 32'd0;
    case (off)
      32'd0:   return {24'd0, m_ie};
      32'd4:   return {24'd0, m_ip};
      32'd8:   return {27'd0, m_cause};
      default: return {31'd0, m_gie};
    endcase
  endfunction

  // Advance one clock with the currently driven inputs, updating the model alongside.
  task automatic cycle();
    bit [7:0]  set_v, pend, n_ie, n_ip, clr;
    bit        n_gie, n_irq, hit;
    bit [4:0]  n_cause;
    bit [31:0] off;
    int        n_phase;
    if (reset) begin
      n_ie = 0; n_ip = 0; n_gie = 0; n_irq = 0; n_cause = 0; n_phase = 0;
    end else begin
      off   = addr - BASE;
      hit   = wr && off <= 32'd15 && off[1:0] == 2'b00;
      set_v = src & ~m_src_prev;
      pend  = m_ip & m_ie;
      n_irq = 0; n_cause = m_cause; n_phase = m_phase;
      if (m_phase == 0) begin
        if (pend != 0 && m_gie && !pc_kernel) begin
          n_irq = 1; n_cause = 5'(16 + lowest(pend)); n_phase = 1;
        end
      end else if (m_phase == 1) begin
        n_phase = 2;
      end else if (m_pk_prev && !pc_kernel) begin
        n_phase = 0; n_cause[4] = 1'b0;
      end
      clr   = (hit && off == 32'd4) ? wdata[7:0] : 8'd0;
      n_ie  = (hit && off == 32'd0) ? wdata[7:0] : m_ie;
      n_ip  = (m_ip & ~clr) | set_v;
      n_gie = (hit && off == 32'd12) ? wdata[0] : m_gie;
    end
    @(posedge clk);
    #1;
    m_ie = n_ie; m_ip = n_ip; m_gie = n_gie; m_irq = n_irq; m_cause = n_cause;
    m_phase = n_phase;
    m_src_prev = reset ? 8'd0 : src;
    m_pk_prev  = reset ? 1'b0 : pc_kernel;
  endtask

  task automatic bus_write(input bit [31:0] a, input bit [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    cycle();
    wr = 1'b0; addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cmp_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL reset_irq: got %b expected 0", irq); end
    cmp_cnt++; if (cause !== 5'd0) begin err_cnt++; $display("FAIL reset_cause: got %h expected 00", cause); end
    for (int k = 0; k < 4; k++) begin
      rd = 1'b1; addr = BASE + 32'(4 * k);
      #1;
      cmp_cnt++;
      if (rdata !== 32'd0) begin err_cnt++; $display("FAIL reset_reg%0d: got %h expected 0", k, rdata); end
      $display("reset read off=%0d rdata=%h", 4 * k, rdata);
    end
    rd = 1'b0; addr = '0;
  endtask

  task automatic test_basic();
    src = 8'h00; pc_kernel = 1'b0;
    bus_write(BASE + 0, 32'h01);
    bus_write(BASE + 12, 32'h1);
    repeat (3) cycle();
    src = 8'h01;
    cycle();
    cmp_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL basic_early: got %b expected 0", irq); end
    rd = 1'b1; addr = BASE + 4; #1;
    cmp_cnt++; if (rdata !== 32'h1) begin err_cnt++; $display("FAIL basic_ip: got %h expected 1", rdata); end
    rd = 1'b0;
    cycle();
    cmp_cnt++; if (irq !== 1'b1 || cause !== 5'h10) begin
      err_cnt++; $display("FAIL basic_irq: got irq=%b cause=%h expected irq=1 cause=10", irq, cause); end
    $display("basic: irq=%b cause=%h", irq, cause);
    cycle();
    cmp_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL basic_oneshot: got %b expected 0", irq); end
  endtask

  task automatic test_service_block();
    pc_kernel = 1'b1;
    cycle();
    bus_write(BASE + 0, 32'h03);
    src = 8'h03;
    for (int k = 0; k < 4; k++) begin
      cycle();
      cmp_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL service_block%0d: got %b expected 0", k, irq); end
    end
    bus_write(BASE + 4, 32'h01);
    pc_kernel = 1'b0;
    cycle();
    cmp_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL service_exit: got %b expected 0", irq); end
    cycle();
    cmp_cnt++; if (irq !== 1'b1 || cause !== 5'h11) begin
      err_cnt++; $display("FAIL service_next: got irq=%b cause=%h expected irq=1 cause=11", irq, cause); end
    $display("service: second irq=%b cause=%h", irq, cause);
    cycle();
    pc_kernel = 1'b1; cycle();
    bus_write(BASE + 4, 32'h02);
    pc_kernel = 1'b0; cycle();
    cycle();
    cmp_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL service_quiet: got %b expected 0", irq); end
    src = 8'h00; cycle();
  endtask

  task automatic test_simultaneous();
    bus_write(BASE + 0, 32'hFF);
    src = 8'h24;
    cycle(); cycle();
    cmp_cnt++; if (irq !== 1'b1 || cause !== 5'h12) begin
      err_cnt++; $display("FAIL simul_first: got irq=%b cause=%h expected irq=1 cause=12", irq, cause); end
    cycle();
    pc_kernel = 1'b1; cycle();
    bus_write(BASE + 4, 32'h04);
    pc_kernel = 1'b0; cycle(); cycle();
    cmp_cnt++; if (irq !== 1'b1 || cause !== 5'h15) begin
      err_cnt++; $display("FAIL simul_second: got irq=%b cause=%h expected irq=1 cause=15", irq, cause); end
    $display("simultaneous: second cause=%h", cause);
    cycle();
    pc_kernel = 1'b1; cycle();
    bus_write(BASE + 4, 32'h20);
    pc_kernel = 1'b0; cycle();
    cmp_cnt++; if (cause !== 5'h05) begin err_cnt++; $display("FAIL simul_exit_cause: got %h expected 05", cause); end
    cycle();
    src = 8'h00; cycle();
  endtask

  task automatic test_w1c_race();
    bus_write(BASE + 12, 32'h0);
    src = 8'h00; cycle();
    addr = BASE + 4; wdata = 32'h1; wr = 1'b1; src = 8'h01;
    cycle();
    wr = 1'b0; rd = 1'b1; addr = BASE + 4; #1;
    cmp_cnt++; if (rdata !== 32'h1) begin err_cnt++; $display("FAIL w1c_race: got %h expected 1", rdata); end
    $display("w1c race: ip=%h", rdata);
    rd = 1'b0;
    bus_write(BASE + 4, 32'h1);
    rd = 1'b1; addr = BASE + 4; #1;
    cmp_cnt++; if (rdata !== 32'h0) begin err_cnt++; $display("FAIL w1c_clear: got %h expected 0", rdata); end
    rd = 1'b0; src = 8'h00; cycle();
  endtask

  task automatic test_kernel_hold();
    bus_write(BASE + 0, 32'h01);
    bus_write(BASE + 12, 32'h1);
    pc_kernel = 1'b1; src = 8'h00; cycle();
    src = 8'h01;
    for (int k = 0; k < 4; k++) begin
      cycle();
      cmp_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL kernel_hold%0d: got %b expected 0", k, irq); end
    end
    pc_kernel = 1'b0; cycle();
    cmp_cnt++; if (irq !== 1'b1 || cause !== 5'h10) begin
      err_cnt++; $display("FAIL kernel_release: got irq=%b cause=%h expected irq=1 cause=10", irq, cause); end
    $display("kernel hold: release irq=%b cause=%h", irq, cause);
  endtask

  // Entered with the controller in its one-cycle irq state from test_kernel_hold.
  task automatic test_reset_in_req();
    reset = 1'b1; cycle(); reset = 1'b0;
    cmp_cnt++; if (irq !== 1'b0 || cause !== 5'h00) begin
      err_cnt++; $display("FAIL rst_req_out: got irq=%b cause=%h expected irq=0 cause=00", irq, cause); end
    for (int k = 0; k < 4; k++) begin
      rd = 1'b1; addr = BASE + 32'(4 * k); #1;
      cmp_cnt++; if (rdata !== 32'd0) begin err_cnt++; $display("FAIL rst_req_reg%0d: got %h expected 0", k, rdata); end
    end
    rd = 1'b0; src = 8'h00; cycle();
    $display("reset in req: irq=%b cause=%h", irq, cause);
  endtask

  task automatic test_random();
    bit [31:0] exp_rd;
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) src = 8'($urandom);
      if ($urandom_range(0, 4) == 0) pc_kernel = ~pc_kernel;
      wr = ($urandom_range(0, 4) == 0);
      rd = 1'($urandom_range(0, 1));
      addr = BASE + 32'(4 * $urandom_range(0, 4)) + (($urandom_range(0, 15) == 0) ? 32'd1 : 32'd0);
      wdata = $urandom | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
      #1;
      exp_rd = model_read(rd, addr);
      cmp_cnt++;
      if (rdata !== exp_rd) begin
        err_cnt++; $display("FAIL rand_rdata n=%0d addr=%h: got %h expected %h", n, addr, rdata, exp_rd);
      end
      cycle();
      cmp_cnt++;
      if (irq !== m_irq || cause !== m_cause) begin
        err_cnt++;
        $display("FAIL rand_out n=%0d: got irq=%b cause=%h expected irq=%b cause=%h", n, irq, cause, m_irq, m_cause);
      end
      if (m_irq) $display("rand n=%0d irq cause=%h", n, cause);
    end
    reset = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_service_block();
    test_simultaneous();
    test_w1c_race();
    test_kernel_hold();
    test_reset_in_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
